// File: rtl/main_tb_pkg.sv
// Shared types and constants for the main_slave_loader preload/run block.
package main_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_REPORT
  } state_e;

  // Access size reported on the slave port for one byte write, in bits.
  localparam int SIZE_BYTE = 8;
  localparam int CH0 = 0;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200_000_000;

endpackage

// File: rtl/main_slave_loader_if.sv
// Byte stream input plus the multi-channel slave RAM port of the HLS top `main`.
interface main_slave_loader_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int SIZE_W   = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic                       in_last;
  logic [CHANNELS-1:0]        S_oe_ram;
  logic [CHANNELS-1:0]        S_we_ram;
  logic [CHANNELS*ADDR_W-1:0] S_addr_ram;
  logic [CHANNELS*DATA_W-1:0] S_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] S_data_ram_size;
  logic [CHANNELS-1:0]        Sout_DataRdy;

  // The loader is the master of the slave RAM port and the sink of the stream.
  modport master (
    input  in_valid, in_data, in_last, Sout_DataRdy,
    output in_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
  );

  modport slave (
    output in_valid, in_data, in_last, Sout_DataRdy,
    input  in_ready, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
  );
endinterface

// File: rtl/slave_write_port.sv
// Single-channel write request holder: keeps we/addr/data/size stable until ack.
module slave_write_port #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ack,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [SIZE_W-1:0] o_size,
  output logic              o_done
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [SIZE_W-1:0] r_size;

  // Ack only counts while a request is outstanding.
  assign o_done  = r_we & i_ack;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_data;
  assign o_size  = r_size;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_size <= '0;
    end else if (i_load) begin
      r_we   <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
      r_size <= SIZE_W'(DATA_W);
    end else if (o_done) begin
      r_we   <= 1'b0;
      r_size <= '0;
    end
  end

endmodule

// File: rtl/main_slave_loader.sv
// Preloads `main` memory from a byte stream over slave channel 0, then starts
// `main` and reports its run length in cycles, a timeout, or a load overflow.
module main_slave_loader
  import main_tb_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = SIZE_BYTE,
  parameter int SIZE_W         = 4,
  parameter int BASE_ADDR      = 0,
  parameter int MEM_BYTES      = 128,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  main_slave_loader_if.master bus,
  output logic                start_port,
  input  logic                done_port,
  output logic                busy,
  output logic                result_valid,
  output logic                result_timeout,
  output logic                result_overflow,
  output logic [CNT_W-1:0]    result_cycles
);

  localparam int BCNT_W = $clog2(MEM_BYTES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [BCNT_W-1:0]  r_count;
  logic               r_last;
  logic               r_in_ready;
  logic               r_start;
  logic               r_busy;
  logic               r_result_valid;
  logic               r_timeout;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_cycles;

  logic               w_accept;
  logic               w_full;
  logic               w_load;
  logic               w_wr_done;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [SIZE_W-1:0]  w_size;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_unused_ack;

  assign w_accept     = (r_state == ST_LOAD) && bus.in_valid;
  assign w_full       = (r_count == BCNT_W'(MEM_BYTES));
  assign w_load       = w_accept && !w_full;
  assign w_cnt_inc    = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);
  assign w_unused_ack = ^bus.Sout_DataRdy;

  slave_write_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W)
  ) u_wr_port (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_addr  (r_addr),
    .i_data  (bus.in_data),
    .i_ack   (bus.Sout_DataRdy[CH0]),
    .o_we    (w_we),
    .o_addr  (w_addr),
    .o_wdata (w_wdata),
    .o_size  (w_size),
    .o_done  (w_wr_done)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bus.S_oe_ram                                = '0;
    bus.S_we_ram                                = '0;
    bus.S_addr_ram                              = '0;
    bus.S_Wdata_ram                             = '0;
    bus.S_data_ram_size                         = '0;
    bus.S_we_ram[CH0]                           = w_we;
    bus.S_addr_ram[CH0*ADDR_W +: ADDR_W]        = w_addr;
    bus.S_Wdata_ram[CH0*DATA_W +: DATA_W]       = w_wdata;
    bus.S_data_ram_size[CH0*SIZE_W +: SIZE_W]   = w_size;
  end

  assign bus.in_ready     = r_in_ready;
  assign start_port       = r_start;
  assign busy             = r_busy;
  assign result_valid     = r_result_valid;
  assign result_timeout   = r_timeout;
  assign result_overflow  = r_overflow;
  assign result_cycles    = r_cycles;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_count        <= '0;
      r_last         <= 1'b0;
      r_in_ready     <= 1'b0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_overflow     <= 1'b0;
      r_cycles       <= '0;
    end else begin
      r_start        <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_state    <= ST_LOAD;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_full) begin
              // Byte beyond capacity is dropped and the session ends without a run.
              r_overflow     <= 1'b1;
              r_timeout      <= 1'b0;
              r_result_valid <= 1'b1;
              r_state        <= ST_REPORT;
            end else begin
              r_last  <= bus.in_last;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (w_wr_done) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count + BCNT_W'(1);
            if (r_last) begin
              r_start <= 1'b1;
              r_state <= ST_START;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_START: begin
          r_cycles   <= CNT_W'(1);
          r_timeout  <= 1'b0;
          r_overflow <= 1'b0;
          if (done_port) begin
            r_result_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Done takes priority over the limit when both land on the same cycle.
          if (done_port) begin
            r_cycles       <= w_cnt_inc;
            r_result_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else if (w_cnt_inc >= TIMEOUT_LIM) begin
            r_cycles       <= TIMEOUT_LIM;
            r_timeout      <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= ST_REPORT;
          end else begin
            r_cycles <= w_cnt_inc;
          end
        end
        ST_REPORT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_slave_loader.sv
// Self-checking bench: table of load/run sessions, write scoreboard, and
// hand-written reset-abort and overflow sequences.
module tb_main_slave_loader;
  import main_tb_pkg::*;

  typedef struct {
    int          n_bytes;
    logic [7:0]  first;
    int          ack_lat;
    int          done_dly;
    bit          go_in_run;
    logic [31:0] exp_cycles;
    bit          exp_timeout;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0, done = 1'b0;
  logic        start_port, busy, result_valid, result_timeout, result_overflow;
  logic [31:0] result_cycles;
  logic        go_o = 1'b0, done_o = 1'b0;
  logic        start_port_o, busy_o, result_valid_o, result_timeout_o, result_overflow_o;
  logic [31:0] result_cycles_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_start_o = 0;
  logic [14:0] sb_q[$];
  vec_t vecs[6];

  main_slave_loader_if #(.CHANNELS(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4)) bus ();
  main_slave_loader_if #(.CHANNELS(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4)) bus_o ();

  main_slave_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .go(go), .bus(bus.master),
    .start_port(start_port), .done_port(done), .busy(busy),
    .result_valid(result_valid), .result_timeout(result_timeout),
    .result_overflow(result_overflow), .result_cycles(result_cycles)
  );

  main_slave_loader #(.TIMEOUT_CYCLES(50), .MEM_BYTES(2)) dut_o (
    .clock(clock), .reset(reset), .go(go_o), .bus(bus_o.master),
    .start_port(start_port_o), .done_port(done_o), .busy(busy_o),
    .result_valid(result_valid_o), .result_timeout(result_timeout_o),
    .result_overflow(result_overflow_o), .result_cycles(result_cycles_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (start_port)   n_start++;
    if (start_port_o) n_start_o++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] all_outs();
    return {busy, start_port, result_valid, result_timeout, result_overflow, result_cycles,
            bus.in_ready, bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram, bus.S_Wdata_ram,
            bus.S_data_ram_size};
  endfunction

  task automatic run_session(input vec_t v);
    int         n0;
    bit         got;
    bit         wr_in_run;
    logic [7:0] b;
    logic [14:0] e;
    n0 = n_start;
    got = 1'b0;
    wr_in_run = 1'b0;
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
    for (int i = 0; i < v.n_bytes; i++) begin
      b = v.first + 8'(i * 17);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = (i == v.n_bytes - 1);
      for (int t = 0; t < 20 && !bus.in_ready; t++) @(negedge clock);
      check("in_ready", bus.in_ready, 1);
      sb_q.push_back({7'(i), b});
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      for (int t = 0; t < v.ack_lat; t++) @(negedge clock);
      check("we_held", {bus.in_ready, bus.S_we_ram[CH0]}, 2'b01);
      if (i == 0)
        check("ch1_idle", {bus.S_oe_ram, bus.S_we_ram[1], bus.S_addr_ram[13:7],
                           bus.S_Wdata_ram[15:8], bus.S_data_ram_size[7:4]}, 0);
      e = sb_q.pop_front();
      check("write", {bus.S_addr_ram[6:0], bus.S_Wdata_ram[7:0], bus.S_data_ram_size[3:0]},
            {e, 4'd8});
      bus.Sout_DataRdy = 2'b01;
      @(negedge clock);
      bus.Sout_DataRdy = 2'b00;
    end
    for (int t = 0; t < 10 && !start_port; t++) @(negedge clock);
    check("start_seen", start_port, 1);
    done = (v.done_dly == 0);
    for (int k = 1; k <= 80 && !got; k++) begin
      @(negedge clock);
      if (result_valid) got = 1'b1;
      if (bus.S_we_ram[CH0]) wr_in_run = 1'b1;
      done = (k == v.done_dly);
      go   = v.go_in_run && (k == 2);
    end
    done = 1'b0;
    go   = 1'b0;
    check("result_valid_seen", got, 1);
    check("result", {result_timeout, result_overflow, result_cycles},
          {v.exp_timeout, 1'b0, v.exp_cycles});
    check("start_pulses", n_start - n0, 1);
    check("no_write_in_run", wr_in_run, 0);
    @(negedge clock);
    check("post_report", {result_valid, busy, bus.in_ready, bus.S_data_ram_size, result_cycles},
          {3'b000, 8'h00, v.exp_cycles});
    @(negedge clock);
    check("stays_idle", {busy, bus.in_ready}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{4, 8'h11, 2, 10, 1'b0, 32'd11, 1'b0};
    vecs[1] = '{1, 8'hA5, 0,  0, 1'b0, 32'd1,  1'b0};
    vecs[2] = '{2, 8'h3C, 1, -1, 1'b0, 32'd50, 1'b1};
    vecs[3] = '{3, 8'hF0, 3, 49, 1'b0, 32'd50, 1'b0};
    vecs[4] = '{2, 8'h80, 0, 48, 1'b1, 32'd49, 1'b0};
    vecs[5] = '{1, 8'h5A, 1,  2, 1'b1, 32'd3,  1'b0};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.Sout_DataRdy = '0;
    bus_o.in_valid = 1'b0; bus_o.in_data = '0; bus_o.in_last = 1'b0; bus_o.Sout_DataRdy = '0;

    repeat (3) @(negedge clock);
    check("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", all_outs(), 0);

    for (int i = 0; i < 5; i++) run_session(vecs[i]);

    // Abort during a pending write.
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.in_last = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("abort_we_high", {busy, bus.S_we_ram[CH0]}, 2'b11);
    reset = 1'b0;
    #1;
    check("abort_outputs_zero", all_outs(), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_no_strobe", {result_valid, busy}, 2'b00);
    run_session(vecs[5]);

    // Overflow on a two-byte memory.
    @(negedge clock); go_o = 1'b1;
    @(negedge clock); go_o = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus_o.in_valid = 1'b1;
      bus_o.in_data  = 8'hC0 + 8'(b);
      bus_o.in_last  = 1'b0;
      check("ovf_ready", bus_o.in_ready, 1);
      @(negedge clock);
      bus_o.in_valid = 1'b0;
      if (b < 2) begin
        check("ovf_write", {bus_o.S_we_ram[CH0], bus_o.S_addr_ram[6:0], bus_o.S_Wdata_ram[7:0]},
              {1'b1, 7'(b), 8'hC0 + 8'(b)});
        bus_o.Sout_DataRdy = 2'b01;
        @(negedge clock);
        bus_o.Sout_DataRdy = 2'b00;
      end
    end
    check("ovf_result", {result_valid_o, result_overflow_o, result_timeout_o, bus_o.S_we_ram},
          5'b11000);
    @(negedge clock);
    check("ovf_idle", {busy_o, result_valid_o, result_overflow_o}, 3'b001);
    check("ovf_no_start", n_start_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
